// File: rtl/avs_uart_regfile_if.sv
// Avalon-MM slave bus bundle for avs_uart_regfile (address, read/write strobes, data, waitrequest).
interface avs_uart_regfile_if;
  logic [4:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/avs_uart_regfile.sv
// Avalon-MM UART host register file: RX data @0, TX data @4, STATUS @8, each direction behind a byte FIFO.
// Optional macro AVS_UART_ERR_EN adds sticky RX_UNDERFLOW (STATUS[0]) and TX_DROP (STATUS[1]), cleared by a write to 8.
module avs_uart_regfile #(
  parameter int FIFO_DEPTH  = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              avm_clk,
  input  logic              avm_rst_n,
  avs_uart_regfile_if.slave avs,
  input  logic              rx_byte_valid,
  input  logic [7:0]        rx_byte_data,
  output logic              rx_byte_ready,
  output logic              tx_byte_valid,
  output logic [7:0]        tx_byte_data,
  input  logic              tx_byte_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_read_q, is_read_d;
  logic        is_write_q, is_write_d;
  logic [4:0]  addr_q, addr_d;
  logic [7:0]  wbyte_q, wbyte_d;
  logic        pop_ok_q, pop_ok_d;
  logic [31:0] rdata_q, rdata_d;

  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;

  logic        ack, go_ack, rx_empty, op_read;
  logic [4:0]  op_addr;
  logic [31:0] status, snapshot;
  logic        rx_push, rx_pop, tx_push, tx_pop;
  logic        unused_wdata;

  assign unused_wdata = ^avs.avs_writedata[31:8];

`ifdef AVS_UART_ERR_EN
  logic underflow_q, underflow_d, drop_q, drop_d;
`endif

  assign ack                 = (state_q == ACK);
  assign rx_empty            = (rx_cnt_q == '0);
  assign avs.avs_waitrequest = !ack;
  assign avs.avs_readdata    = rdata_q;
  assign rx_byte_ready       = (rx_cnt_q != FULL);
  assign tx_byte_valid       = (tx_cnt_q != '0);
  assign tx_byte_data        = tx_mem_q[tx_rd_q];

  // With WAIT_CYCLES=0 the snapshot is taken straight from IDLE, so use the live request there
  always_comb begin
    op_read = (state_q == IDLE) ? avs.avs_read : is_read_q;
    op_addr = (state_q == IDLE) ? avs.avs_address : addr_q;
    status = '0;
    status[7] = !rx_empty;
    status[6] = (tx_cnt_q != FULL);
`ifdef AVS_UART_ERR_EN
    status[0] = underflow_q;
    status[1] = drop_q;
`endif
    snapshot = '0;
    if (op_read) begin
      case (op_addr)
        5'd0:    if (!rx_empty) snapshot = {24'b0, rx_mem_q[rx_rd_q]};
        5'd8:    snapshot = status;
        default: snapshot = '0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_read_d  = is_read_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wbyte_d    = wbyte_q;
    pop_ok_d   = pop_ok_q;
    rdata_d    = '0;
    go_ack     = 1'b0;
    case (state_q)
      IDLE: begin
        if (avs.avs_read || avs.avs_write) begin
          is_read_d  = avs.avs_read;
          is_write_d = avs.avs_write && !avs.avs_read;
          addr_d     = avs.avs_address;
          wbyte_d    = avs.avs_writedata[7:0];
          cnt_d      = WAIT_INIT;
          if (WAIT_INIT == 4'd0) go_ack = 1'b1;
          else                   state_d = WAIT;
        end
      end
      WAIT: begin
        if (!avs.avs_read && !avs.avs_write) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) go_ack = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Whether the RX pop is allowed is frozen with the snapshot so the data returned and the pop agree
    if (go_ack) begin
      state_d  = ACK;
      rdata_d  = snapshot;
      pop_ok_d = !rx_empty;
    end
  end

  always_comb begin
    rx_push  = rx_byte_valid && (rx_cnt_q != FULL);
    rx_pop   = ack && is_read_q && (addr_q == 5'd0) && pop_ok_q;
    tx_push  = ack && is_write_q && (addr_q == 5'd4) && (tx_cnt_q != FULL);
    tx_pop   = (tx_cnt_q != '0) && tx_byte_ready;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    if (rx_push) rx_wr_d = rx_wr_q + AW'(1);
    if (rx_pop)  rx_rd_d = rx_rd_q + AW'(1);
    if (tx_push) tx_wr_d = tx_wr_q + AW'(1);
    if (tx_pop)  tx_rd_d = tx_rd_q + AW'(1);
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
  end

`ifdef AVS_UART_ERR_EN
  // Set wins over clear when both land on the same edge
  always_comb begin
    logic clr, set_uf, set_dr;
    clr    = ack && is_write_q && (addr_q == 5'd8);
    set_uf = ack && is_read_q && (addr_q == 5'd0) && !pop_ok_q;
    set_dr = ack && is_write_q && (addr_q == 5'd4) && (tx_cnt_q == FULL);
    underflow_d = (underflow_q && !clr) || set_uf;
    drop_d      = (drop_q && !clr) || set_dr;
  end

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      underflow_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
      drop_q      <= drop_d;
    end
  end
`endif

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_read_q  <= 1'b0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wbyte_q    <= '0;
      pop_ok_q   <= 1'b0;
      rdata_q    <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_read_q  <= is_read_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      wbyte_q    <= wbyte_d;
      pop_ok_q   <= pop_ok_d;
      rdata_q    <= rdata_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  always_ff @(posedge avm_clk) begin
    if (rx_push) rx_mem_q[rx_wr_q] <= rx_byte_data;
    if (tx_push) tx_mem_q[tx_wr_q] <= wbyte_q;
  end
endmodule

// File: tb/tb_avs_uart_regfile.sv
// Self-checking bench for avs_uart_regfile: directed scenarios plus randomized traffic against a queue-based model.
module tb_avs_uart_regfile;
  localparam int DEPTH = 16;
  localparam int WAITC = 1;
  localparam int LAT   = 1 + WAITC;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_byte_valid, rx_byte_ready, tx_byte_valid, tx_byte_ready;
  logic [7:0] rx_byte_data, tx_byte_data;

  avs_uart_regfile_if avs();

  avs_uart_regfile #(.FIFO_DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .avm_clk(clk), .avm_rst_n(rst_n), .avs(avs),
    .rx_byte_valid(rx_byte_valid), .rx_byte_data(rx_byte_data), .rx_byte_ready(rx_byte_ready),
    .tx_byte_valid(tx_byte_valid), .tx_byte_data(tx_byte_data), .tx_byte_ready(tx_byte_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] tx_got[$];
  bit m_underflow, m_drop;

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[7] = (rx_q.size() != 0);
    s[6] = (tx_q.size() < DEPTH);
`ifdef AVS_UART_ERR_EN
    s[0] = m_underflow;
    s[1] = m_drop;
`endif
    return s;
  endfunction

  // Applies one whole bus access to the model and returns the data the host should see
  function automatic logic [31:0] model_access(input bit rd, input bit wr, input logic [4:0] addr, input logic [31:0] wd);
    logic [31:0] r;
    logic [7:0]  b;
    r = '0;
    if (rd) begin
      if (addr == 5'd0) begin
        if (rx_q.size() != 0) begin
          b = rx_q.pop_front();
          r = {24'b0, b};
        end else m_underflow = 1'b1;
      end else if (addr == 5'd8) r = model_status();
    end else if (wr) begin
      if (addr == 5'd4) begin
        if (tx_q.size() < DEPTH) tx_q.push_back(wd[7:0]);
        else m_drop = 1'b1;
      end else if (addr == 5'd8) begin
        m_underflow = 1'b0;
        m_drop = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic bus_access(input bit rd, input bit wr, input logic [4:0] addr, input logic [31:0] wd,
                            output logic [31:0] rdata, output int lat);
    lat = 0;
    avs.avs_read = rd;
    avs.avs_write = wr;
    avs.avs_address = addr;
    avs.avs_writedata = wd;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (avs.avs_waitrequest !== 1'b0 && lat < 64);
    rdata = avs.avs_readdata;
    avs.avs_read = 1'b0;
    avs.avs_write = 1'b0;
    @(posedge clk); #1;
    if (lat >= 64) lat = -1;
  endtask

  task automatic rx_push_byte(input logic [7:0] b, output logic seen_ready);
    bit will_accept;
    will_accept = (rx_q.size() < DEPTH);
    rx_byte_valid = 1'b1;
    rx_byte_data = b;
    seen_ready = rx_byte_ready;
    @(posedge clk); #1;
    rx_byte_valid = 1'b0;
    if (will_accept) rx_q.push_back(b);
  endtask

  task automatic tx_drain();
    int n;
    tx_got.delete();
    tx_byte_ready = 1'b1;
    n = 0;
    while (tx_byte_valid === 1'b1 && n < 4 * DEPTH) begin
      tx_got.push_back(tx_byte_data);
      @(posedge clk); #1;
      n++;
    end
    tx_byte_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rx_q.delete();
    tx_q.delete();
    m_underflow = 1'b0;
    m_drop = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (avs.avs_waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL reset_waitrequest got %b exp 1", avs.avs_waitrequest); end
    checks++; if (avs.avs_readdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_readdata got %h exp 0", avs.avs_readdata); end
    checks++; if (rx_byte_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_rx_ready got %b exp 1", rx_byte_ready); end
    checks++; if (tx_byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid got %b exp 0", tx_byte_valid); end
  endtask

  task automatic test_status_latency();
    logic [31:0] rd, exp;
    int lat;
    exp = model_access(1'b1, 1'b0, 5'd8, 32'h0);
    bus_access(1'b1, 1'b0, 5'd8, 32'h0, rd, lat);
    checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL status_latency got %0d exp %0d", lat, LAT); end
    checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL status_after_reset got %h exp %h", rd, exp); end
  endtask

  task automatic test_rx_stream();
    logic [31:0] rd, exp;
    int lat;
    logic rdy;
    rx_push_byte(8'h41, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL rx_ready_41 got %b exp 1", rdy); end
    rx_push_byte(8'h42, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL rx_ready_42 got %b exp 1", rdy); end
    for (int i = 0; i < 4; i++) begin
      logic [4:0] a;
      a = (i == 0 || i == 3) ? 5'd8 : 5'd0;
      exp = model_access(1'b1, 1'b0, a, 32'h0);
      bus_access(1'b1, 1'b0, a, 32'h0, rd, lat);
      checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL rx_stream_step%0d got %h exp %h", i, rd, exp); end
    end
  endtask

  task automatic test_tx_single();
    logic [31:0] rd, exp;
    int lat;
    tx_byte_ready = 1'b1;
    exp = model_access(1'b0, 1'b1, 5'd4, 32'h1A5);
    bus_access(1'b0, 1'b1, 5'd4, 32'h1A5, rd, lat);
    checks++; if (tx_byte_valid !== 1'b1) begin errors++; $display("[TB] FAIL tx_single_valid got %b exp 1", tx_byte_valid); end
    checks++; if (tx_byte_data !== tx_q[0]) begin errors++; $display("[TB] FAIL tx_single_data got %h exp %h", tx_byte_data, tx_q[0]); end
    void'(tx_q.pop_front());
    @(posedge clk); #1;
    checks++; if (tx_byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL tx_single_one_cycle got %b exp 0", tx_byte_valid); end
    tx_byte_ready = 1'b0;
  endtask

  task automatic test_tx_overflow();
    logic [31:0] rd, exp, wd;
    int lat;
    for (int i = 0; i < DEPTH + 1; i++) begin
      wd = $urandom;
      exp = model_access(1'b0, 1'b1, 5'd4, wd);
      bus_access(1'b0, 1'b1, 5'd4, wd, rd, lat);
      checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL tx_fill_latency%0d got %0d exp %0d", i, lat, LAT); end
      if (i == DEPTH - 1) begin
        exp = model_access(1'b1, 1'b0, 5'd8, 32'h0);
        bus_access(1'b1, 1'b0, 5'd8, 32'h0, rd, lat);
        checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL tx_full_status got %h exp %h", rd, exp); end
      end
    end
    exp = model_access(1'b1, 1'b0, 5'd8, 32'h0);
    bus_access(1'b1, 1'b0, 5'd8, 32'h0, rd, lat);
    checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL tx_drop_status got %h exp %h", rd, exp); end
    tx_drain();
    checks++; if (tx_got.size() !== tx_q.size()) begin errors++; $display("[TB] FAIL tx_drain_count got %0d exp %0d", tx_got.size(), tx_q.size()); end
    for (int i = 0; i < tx_got.size() && i < tx_q.size(); i++) begin
      checks++; if (tx_got[i] !== tx_q[i]) begin errors++; $display("[TB] FAIL tx_drain_byte%0d got %h exp %h", i, tx_got[i], tx_q[i]); end
    end
    tx_q.delete();
    exp = model_access(1'b1, 1'b0, 5'd8, 32'h0);
    bus_access(1'b1, 1'b0, 5'd8, 32'h0, rd, lat);
    checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL tx_sticky_kept got %h exp %h", rd, exp); end
    exp = model_access(1'b0, 1'b1, 5'd8, 32'h0);
    bus_access(1'b0, 1'b1, 5'd8, 32'h0, rd, lat);
    exp = model_access(1'b1, 1'b0, 5'd8, 32'h0);
    bus_access(1'b1, 1'b0, 5'd8, 32'h0, rd, lat);
    checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL tx_sticky_cleared got %h exp %h", rd, exp); end
  endtask

  task automatic test_rx_full_pop();
    logic [31:0] rd, exp;
    int lat;
    logic rdy;
    logic [7:0] extra;
    for (int i = 0; i < DEPTH; i++) begin
      rx_push_byte(8'($urandom), rdy);
      checks++; if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL rx_fill_ready%0d got %b exp 1", i, rdy); end
    end
    extra = 8'($urandom);
    rx_byte_valid = 1'b1;
    rx_byte_data = extra;
    checks++; if (rx_byte_ready !== 1'b0) begin errors++; $display("[TB] FAIL rx_full_ready got %b exp 0", rx_byte_ready); end
    avs.avs_read = 1'b1;
    avs.avs_address = 5'd0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (avs.avs_waitrequest !== 1'b0 && lat < 64);
    exp = model_access(1'b1, 1'b0, 5'd0, 32'h0);
    checks++; if (avs.avs_readdata !== exp) begin errors++; $display("[TB] FAIL rx_full_pop_data got %h exp %h", avs.avs_readdata, exp); end
    checks++; if (rx_byte_ready !== 1'b0) begin errors++; $display("[TB] FAIL rx_ready_in_ack got %b exp 0", rx_byte_ready); end
    avs.avs_read = 1'b0;
    @(posedge clk); #1;
    checks++; if (rx_byte_ready !== 1'b1) begin errors++; $display("[TB] FAIL rx_ready_after_pop got %b exp 1", rx_byte_ready); end
    @(posedge clk); #1;
    rx_byte_valid = 1'b0;
    rx_q.push_back(extra);
    checks++; if (rx_byte_ready !== 1'b0) begin errors++; $display("[TB] FAIL rx_refull_ready got %b exp 0", rx_byte_ready); end
    for (int i = 0; i < DEPTH + 1; i++) begin
      exp = model_access(1'b1, 1'b0, 5'd0, 32'h0);
      bus_access(1'b1, 1'b0, 5'd0, 32'h0, rd, lat);
      checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL rx_drain%0d got %h exp %h", i, rd, exp); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd, exp;
    int lat;
    logic rdy;
    rx_push_byte(8'h5C, rdy);
    avs.avs_read = 1'b1;
    avs.avs_address = 5'd0;
    @(posedge clk); #1;
    avs.avs_read = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (avs.avs_waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL abort_waitrequest got %b exp 1", avs.avs_waitrequest); end
    end
    exp = model_access(1'b1, 1'b0, 5'd0, 32'h0);
    bus_access(1'b1, 1'b0, 5'd0, 32'h0, rd, lat);
    checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL abort_no_pop got %h exp %h", rd, exp); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, exp;
    int lat;
    for (int i = 0; i < 3; i++) begin
      exp = model_access(1'b1, 1'b0, 5'd8, 32'h0);
      bus_access(1'b1, 1'b0, 5'd8, 32'h0, rd, lat);
      checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL b2b_latency%0d got %0d exp %0d", i, lat, LAT); end
      checks++; if (avs.avs_waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL b2b_idle_gap%0d got %b exp 1", i, avs.avs_waitrequest); end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd, exp;
    int lat;
    logic rdy;
    rx_push_byte(8'h77, rdy);
    avs.avs_write = 1'b1;
    avs.avs_address = 5'd4;
    avs.avs_writedata = $urandom;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    avs.avs_write = 1'b0;
    checks++; if (avs.avs_waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_waitrequest got %b exp 1", avs.avs_waitrequest); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    rx_q.delete();
    tx_q.delete();
    m_underflow = 1'b0;
    m_drop = 1'b0;
    @(posedge clk); #1;
    checks++; if (avs.avs_waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_waitrequest got %b exp 1", avs.avs_waitrequest); end
    checks++; if (tx_byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_no_tx_push got %b exp 0", tx_byte_valid); end
    exp = model_access(1'b1, 1'b0, 5'd8, 32'h0);
    bus_access(1'b1, 1'b0, 5'd8, 32'h0, rd, lat);
    checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL rst_status got %h exp %h", rd, exp); end
  endtask

  // Random mix of stream pushes, reads, writes, odd addresses and drains
  task automatic test_random();
    logic [31:0] rd, exp, wd;
    logic [4:0]  a;
    int lat, op;
    logic rdy, exp_rdy;
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 6);
      wd = $urandom;
      case (op)
        0: begin
          exp_rdy = (rx_q.size() < DEPTH);
          rx_push_byte(wd[7:0], rdy);
          checks++; if (rdy !== exp_rdy) begin errors++; $display("[TB] FAIL rnd_rx_ready%0d got %b exp %b", it, rdy, exp_rdy); end
        end
        5: begin
          tx_drain();
          checks++; if (tx_got.size() !== tx_q.size()) begin errors++; $display("[TB] FAIL rnd_drain_count%0d got %0d exp %0d", it, tx_got.size(), tx_q.size()); end
          for (int i = 0; i < tx_got.size() && i < tx_q.size(); i++) begin
            checks++; if (tx_got[i] !== tx_q[i]) begin errors++; $display("[TB] FAIL rnd_drain_byte%0d got %h exp %h", it, tx_got[i], tx_q[i]); end
          end
          tx_q.delete();
        end
        default: begin
          bit r, w;
          r = (op == 1 || op == 2 || op == 6);
          w = (op == 3 || op == 4 || op == 6);
          case (op)
            1: a = 5'd0;
            2: a = 5'd8;
            3: a = 5'd4;
            4: a = ($urandom_range(0, 1) == 0) ? 5'd8 : 5'(12 + $urandom_range(0, 19));
            default: a = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd4;
          endcase
          exp = model_access(r, w, a, wd);
          bus_access(r, w, a, wd, rd, lat);
          checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL rnd_latency%0d got %0d exp %0d", it, lat, LAT); end
          checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL rnd_data%0d op%0d addr%0d got %h exp %h", it, op, a, rd, exp); end
        end
      endcase
      checks++; if (tx_byte_valid !== (tx_q.size() != 0)) begin errors++; $display("[TB] FAIL rnd_tx_valid%0d got %b exp %b", it, tx_byte_valid, tx_q.size() != 0); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rx_byte_valid = 1'b0;
    rx_byte_data = 8'h0;
    tx_byte_ready = 1'b0;
    avs.avs_read = 1'b0;
    avs.avs_write = 1'b0;
    avs.avs_address = 5'd0;
    avs.avs_writedata = 32'h0;
    test_reset();
    test_status_latency();
    test_rx_stream();
    test_tx_single();
    test_tx_overflow();
    test_rx_full_pop();
    test_abort();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    $display("[TB] FAIL watchdog got timeout exp completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
